// File: rtl/fifo_uart_tx.sv
// ---------------------------------------------------------------------------
// fifo_uart_tx
//
// Purpose
//   Pulls bytes from the read side of a FIFO and serialises each one as an
//   8N1 UART frame: start bit (0), eight data bits LSB first, stop bit (1).
//   A new byte is requested only while idle, so a frame is never disturbed
//   by activity on the FIFO flags.
//
// Optional feature
//   FIFO_UART_TX_PARITY_EN : when defined, an even-parity bit (XOR of the
//   eight data bits) is inserted between the last data bit and the stop bit.
//   When undefined there is no parity state and no parity logic.
//
// Parameters
//   CLKS_PER_BIT : rclk cycles per serial bit (2..65535), default 16.
//
// Ports
//   rclk      in   single clock, all state changes on its rising edge
//   rrst      in   asynchronous active-high reset
//   empty     in   FIFO empty flag (read side)
//   fifo_dout in   FIFO registered read data, valid the cycle after a read
//   ren       out  FIFO read enable (combinational, only ever high in IDLE)
//   tx        out  serial line, registered, idles high
//   busy      out  high in every state except IDLE
//   tx_done   out  one-cycle pulse in the final cycle of each stop bit
//
// Handshake
//   The FIFO read is a single-cycle request: ren = IDLE && !empty (and not
//   in reset).  The edge at which ren is high is the accepted read; the byte
//   appears on fifo_dout during the following (LOAD) cycle and is captured
//   at the edge that closes LOAD.  No back-pressure exists toward the FIFO.
//
// State visibility
//   The FSM state lives in state_q (type state_t) so that checkers can
//   bind to it hierarchically without widening the port list.
// ---------------------------------------------------------------------------
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       rclk,
    input  logic       rrst,
    input  logic       empty,
    input  logic [7:0] fifo_dout,
    output logic       ren,
    output logic       tx,
    output logic       busy,
    output logic       tx_done
);

    // A one-bit counter is still needed when CLKS_PER_BIT would give a
    // zero-width $clog2; the legal range starts at 2 so this never bites
    // in practice but keeps the declaration well formed.
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_START  = 3'd2,
        ST_DATA   = 3'd3,
        ST_STOP   = 3'd4
`ifdef FIFO_UART_TX_PARITY_EN
        , ST_PARITY = 3'd5
`endif
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;    // rclk cycles within current bit
    logic [2:0]       bit_q,   bit_d;    // data bit index 0..7
    logic [7:0]       shift_q, shift_d;  // bit 0 is the data bit on the line
    logic             tx_q,    tx_d;
`ifdef FIFO_UART_TX_PARITY_EN
    logic             parity_q, parity_d;
`endif

    logic bit_end;

    // Last cycle of the bit currently on the line.
    assign bit_end = (cnt_q == CNT_LAST);

    // The read request is gated by reset so the FIFO is never popped while
    // the transmitter is held, whatever empty does.
    assign ren     = (state_q == ST_IDLE) && !empty && !rrst;
    assign busy    = (state_q != ST_IDLE);
    assign tx_done = (state_q == ST_STOP) && bit_end;
    assign tx      = tx_q;

    // -----------------------------------------------------------------------
    // Next-state, counters and datapath
    // -----------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
`ifdef FIFO_UART_TX_PARITY_EN
        parity_d = parity_q;
`endif

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                bit_d = '0;
                if (ren) begin
                    state_d = ST_LOAD;
                end
            end

            // fifo_dout is valid during this cycle only; grab it here.
            ST_LOAD: begin
                cnt_d   = '0;
                bit_d   = '0;
                shift_d = fifo_dout;
`ifdef FIFO_UART_TX_PARITY_EN
                parity_d = ^fifo_dout;
`endif
                state_d = ST_START;
            end

            ST_START: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = ST_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_DATA: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        bit_d = '0;
`ifdef FIFO_UART_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

`ifdef FIFO_UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = ST_STOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`endif

            ST_STOP: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                cnt_d   = '0;
                bit_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Line value: derived from the *next* state so the registered tx lines up
    // exactly with the state it belongs to (no one-cycle lag, no glitches).
    // -----------------------------------------------------------------------
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
`ifdef FIFO_UART_TX_PARITY_EN
            ST_PARITY: tx_d = parity_q;
`endif
            ST_STOP:   tx_d = 1'b1;
            default:   tx_d = 1'b1;
        endcase
    end

    // -----------------------------------------------------------------------
    // State registers.  Reset is asynchronous so a reset mid-frame returns
    // the line high immediately and drops the partial byte.
    // -----------------------------------------------------------------------
    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

`ifdef FIFO_UART_TX_PARITY_EN
    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_fifo_uart_tx
//
// Directed bench for fifo_uart_tx at CLKS_PER_BIT = 4.  A single initial
// process drives every input; a small FIFO model (byte_q) answers ren with
// data on fifo_dout the cycle after the read.  Outputs are sampled on the
// falling edge, inputs change 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_fifo_uart_tx;

    localparam int C = 4;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       rclk;
    logic       rrst;
    logic       empty;
    logic [7:0] fifo_dout;
    logic       ren;
    logic       tx;
    logic       busy;
    logic       tx_done;

    logic [7:0] byte_q[$];
    logic       manual_en;
    logic       manual_empty;

    logic       s_tx, s_ren, s_busy, s_done;

    int checks;
    int passes;
    int fails;
    int ren_cnt;

    fifo_uart_tx #(.CLKS_PER_BIT(C)) dut (
        .rclk      (rclk),
        .rrst      (rrst),
        .empty     (empty),
        .fifo_dout (fifo_dout),
        .ren       (ren),
        .tx        (tx),
        .busy      (busy),
        .tx_done   (tx_done)
    );

    // ---------------- clock ----------------
    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    // ---------------- driver tasks ----------------
    // One rclk cycle: sample outputs mid-cycle, then after the rising edge
    // act as the FIFO (pop on an accepted read) and update empty.
    task automatic tick();
        @(negedge rclk);
        s_tx   = tx;
        s_ren  = ren;
        s_busy = busy;
        s_done = tx_done;
        @(posedge rclk);
        #1;
        if (s_ren === 1'b1) begin
            ren_cnt++;
            if (byte_q.size() > 0) fifo_dout = byte_q.pop_front();
        end
        empty = manual_en ? manual_empty : (byte_q.size() == 0);
    endtask

    task automatic push(input logic [7:0] b);
        byte_q.push_back(b);
        if (!manual_en) empty = 1'b0;
    endtask

    // Runs one frame starting in the IDLE cycle where ren should fire.
    task automatic check_frame(input logic [7:0] b, input bit toggle, input string name);
        logic [0:0] exp_q[$];
        logic [0:0] e;
        int         bad, bad_ren, bad_busy, done_pos, k;
        exp_q.delete();
        exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_q.push_back(b[i]);
`ifdef FIFO_UART_TX_PARITY_EN
        exp_q.push_back(^b);
`endif
        exp_q.push_back(1'b1);

        tick(); // IDLE
        checks++;
        if (s_ren !== 1'b1 || s_tx !== 1'b1 || s_busy !== 1'b0) begin
            fails++;
            $display("FAIL %s idle: got ren=%b tx=%b busy=%b expected ren=1 tx=1 busy=0",
                     name, s_ren, s_tx, s_busy);
        end else passes++;

        if (toggle) begin
            manual_en    = 1'b1;
            manual_empty = 1'b1;
        end
        tick(); // LOAD
        checks++;
        if (s_tx !== 1'b1 || s_busy !== 1'b1 || s_ren !== 1'b0 || s_done !== 1'b0) begin
            fails++;
            $display("FAIL %s load: got tx=%b busy=%b ren=%b done=%b expected 1 1 0 0",
                     name, s_tx, s_busy, s_ren, s_done);
        end else passes++;

        bad_ren  = 0;
        bad_busy = 0;
        done_pos = 0;
        for (int i = 0; i < NB; i++) begin
            e   = exp_q.pop_front();
            bad = 0;
            for (int c = 0; c < C; c++) begin
                k = i * C + c + 1;
                if (toggle) begin
                    if (k == NB * C) manual_en = 1'b0;
                    else manual_empty = ~manual_empty;
                end
                tick();
                if (s_tx !== e) bad++;
                if (s_ren !== 1'b0) bad_ren++;
                if (s_busy !== 1'b1) bad_busy++;
                if (s_done !== 1'b0) done_pos = (done_pos == 0) ? k : -1;
            end
            checks++;
            if (bad != 0) begin
                fails++;
                $display("FAIL %s bit%0d: got tx wrong in %0d of %0d cycles, expected %b",
                         name, i, bad, C, e);
            end else passes++;
        end

        checks++;
        if (bad_ren != 0) begin
            fails++;
            $display("FAIL %s ren_in_frame: got %0d high cycles expected 0", name, bad_ren);
        end else passes++;
        checks++;
        if (bad_busy != 0) begin
            fails++;
            $display("FAIL %s busy_in_frame: got %0d low cycles expected 0", name, bad_busy);
        end else passes++;
        checks++;
        if (done_pos != NB * C) begin
            fails++;
            $display("FAIL %s tx_done_pos: got %0d expected %0d", name, done_pos, NB * C);
        end else passes++;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int bad_tx, bad_busy, bad_done, bad_ren;
        bad_tx = 0; bad_busy = 0; bad_done = 0; bad_ren = 0;
        repeat (3) begin
            tick();
            if (s_tx !== 1'b1) bad_tx++;
            if (s_busy !== 1'b0) bad_busy++;
            if (s_done !== 1'b0) bad_done++;
            if (s_ren !== 1'b0) bad_ren++;
        end
        checks++;
        if (bad_tx != 0) begin fails++; $display("FAIL rst_tx: got %0d bad cycles expected 0", bad_tx); end
        else passes++;
        checks++;
        if (bad_busy != 0) begin fails++; $display("FAIL rst_busy: got %0d bad cycles expected 0", bad_busy); end
        else passes++;
        checks++;
        if (bad_done != 0) begin fails++; $display("FAIL rst_done: got %0d bad cycles expected 0", bad_done); end
        else passes++;
        checks++;
        if (bad_ren != 0) begin fails++; $display("FAIL rst_ren: got %0d bad cycles expected 0", bad_ren); end
        else passes++;
        manual_empty = 1'b1;
        empty        = 1'b1;
        rrst         = 1'b0;
    endtask

    task automatic test_idle_empty();
        int bad;
        bad = 0;
        repeat (100) begin
            tick();
            if (s_ren !== 1'b0 || s_busy !== 1'b0 || s_done !== 1'b0 || s_tx !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            fails++;
            $display("FAIL idle_empty: got %0d disturbed cycles expected 0", bad);
        end else passes++;
        manual_en = 1'b0;
    endtask

    task automatic test_single_frame();
        int bad;
        ren_cnt = 0;
        push(8'hA5);
        check_frame(8'hA5, 1'b0, "a5");
        bad = 0;
        repeat (3) begin
            tick();
            if (s_ren !== 1'b0 || s_busy !== 1'b0 || s_tx !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin fails++; $display("FAIL a5_after: got %0d bad idle cycles expected 0", bad); end
        else passes++;
        checks++;
        if (ren_cnt != 1) begin fails++; $display("FAIL a5_ren_cnt: got %0d expected 1", ren_cnt); end
        else passes++;
    endtask

    task automatic test_back_to_back();
        ren_cnt = 0;
        push(8'h00);
        push(8'hFF);
        check_frame(8'h00, 1'b0, "b2b_00");
        check_frame(8'hFF, 1'b0, "b2b_ff");
        repeat (4) tick();
        checks++;
        if (ren_cnt != 2) begin fails++; $display("FAIL b2b_ren_cnt: got %0d expected 2", ren_cnt); end
        else passes++;
    endtask

    task automatic test_reset_mid_frame();
        int bad;
        ren_cnt = 0;
        push(8'h3C);
        tick(); // IDLE
        tick(); // LOAD
        repeat (4 * 4 + 1) tick(); // START + bits 0..2 + first cycle of bit 3
        checks++;
        if (s_busy !== 1'b1 || s_tx !== 1'b1) begin
            fails++;
            $display("FAIL mid_pre: got busy=%b tx=%b expected busy=1 tx=1", s_busy, s_tx);
        end else passes++;

        rrst = 1'b1;
        #1;
        checks++;
        if (tx !== 1'b1) begin fails++; $display("FAIL mid_rst_tx: got %b expected 1", tx); end
        else passes++;
        checks++;
        if (busy !== 1'b0) begin fails++; $display("FAIL mid_rst_busy: got %b expected 0", busy); end
        else passes++;
        checks++;
        if (tx_done !== 1'b0) begin fails++; $display("FAIL mid_rst_done: got %b expected 0", tx_done); end
        else passes++;

        push(8'h5A);
        bad = 0;
        repeat (3) begin
            tick();
            if (s_ren !== 1'b0 || s_tx !== 1'b1 || s_done !== 1'b0 || s_busy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin fails++; $display("FAIL mid_in_rst: got %0d bad cycles expected 0", bad); end
        else passes++;
        checks++;
        if (ren_cnt != 1) begin fails++; $display("FAIL mid_reread: got %0d reads expected 1", ren_cnt); end
        else passes++;

        rrst = 1'b0;
        check_frame(8'h5A, 1'b0, "after_rst");
        checks++;
        if (ren_cnt != 2) begin fails++; $display("FAIL after_rst_ren_cnt: got %0d expected 2", ren_cnt); end
        else passes++;
    endtask

    task automatic test_empty_toggle();
        ren_cnt = 0;
        push(8'h96);
        check_frame(8'h96, 1'b1, "toggle");
        repeat (3) tick();
        checks++;
        if (ren_cnt != 1) begin fails++; $display("FAIL toggle_ren_cnt: got %0d expected 1", ren_cnt); end
        else passes++;
    endtask

`ifdef FIFO_UART_TX_PARITY_EN
    task automatic test_parity();
        ren_cnt = 0;
        push(8'h07);
        push(8'h03);
        check_frame(8'h07, 1'b0, "par_07");
        check_frame(8'h03, 1'b0, "par_03");
        repeat (3) tick();
        checks++;
        if (ren_cnt != 2) begin fails++; $display("FAIL par_ren_cnt: got %0d expected 2", ren_cnt); end
        else passes++;
    endtask
`endif

    // ---------------- sequence and report ----------------
    initial begin
        checks       = 0;
        passes       = 0;
        fails        = 0;
        ren_cnt      = 0;
        rrst         = 1'b1;
        fifo_dout    = 8'h00;
        manual_en    = 1'b1;
        manual_empty = 1'b0;
        empty        = 1'b0;

        test_reset();
        test_idle_empty();
        test_single_frame();
        test_back_to_back();
        test_reset_mid_frame();
        test_empty_toggle();
`ifdef FIFO_UART_TX_PARITY_EN
        test_parity();
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
